fir_seq_ctrl: RTL and testbench

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

---
 rtl/fir_seq_ctrl.sv | 97 +++++++++
 tb/tb_fir_seq_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequences sample load, compute with timeout, and result readout for an external FIR core
module fir_seq_ctrl #(
  parameter int signalCount = 10,
  parameter int timeoutCycles = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [1:0]  fir_operation,
  output logic [31:0] fir_addr,
  output logic [31:0] fir_x,
  input  logic [31:0] fir_y,
  input  logic        fir_done,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        run_done,
  output logic        err
);
  localparam int IW = $clog2(signalCount + 1);
  localparam int CW = $clog2(timeoutCycles + 1);
  localparam logic [IW-1:0] idx_last = IW'(signalCount - 1);
  localparam logic [CW-1:0] cnt_last = CW'(timeoutCycles - 1);
  localparam logic [31:0] addr_last = 32'(signalCount - 1);
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, READ, ERR} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic accept;
  assign accept = in_ready && in_valid;
  assign out_data = fir_y;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      in_ready <= 1'b0;
      fir_operation <= 2'b00;
      fir_addr <= '0;
      fir_x <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      run_done <= 1'b0;
      err <= 1'b0;
    end else begin
      run_done <= 1'b0;
      case (state)
        IDLE, ERR: if (start) begin
          state <= LOAD;
          idx <= '0;
          in_ready <= 1'b1;
          busy <= 1'b1;
          err <= 1'b0;
        end
        LOAD: begin
          fir_operation <= accept ? 2'b01 : 2'b00;
          if (accept) begin
            fir_x <= in_data;
            fir_addr <= 32'(idx);
            idx <= idx + IW'(1);
            if (idx == idx_last) in_ready <= 1'b0;
          end
          // in_ready low here means the final sample's load command is on the bus now
          if (!in_ready) begin
            state <= COMPUTE;
            fir_operation <= 2'b10;
            cnt <= '0;
          end
        end
        COMPUTE: if (fir_done) begin
          state <= READ;
          fir_operation <= 2'b11;
          fir_addr <= '0;
          out_valid <= 1'b1;
        end else if (cnt == cnt_last) begin
          state <= ERR;
          fir_operation <= 2'b00;
          err <= 1'b1;
          busy <= 1'b0;
        end else cnt <= cnt + CW'(1);
        READ: if (out_ready && fir_addr == addr_last) begin
          state <= IDLE;
          fir_operation <= 2'b00;
          fir_addr <= '0;
          out_valid <= 1'b0;
          busy <= 1'b0;
          run_done <= 1'b1;
        end else if (out_ready) fir_addr <= fir_addr + 32'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb_fir_seq_ctrl: scenario table plus randomized runs checked by a transaction-level scoreboard
module tb_fir_seq_ctrl;
  localparam int N = 10;
  localparam int T = 16;
  logic clk = 1'b0;
  logic reset, start, in_valid, fir_done, out_ready;
  logic [31:0] in_data, fir_y, salt;
  logic in_ready, out_valid, busy, run_done, err;
  logic [1:0] fir_operation;
  logic [31:0] fir_addr, fir_x, out_data;
  int errors = 0, checks = 0;
  bit pend = 0, pend_done = 0;
  logic [31:0] pend_data;
  int exp_idx = 0, rd_idx = 0, acc_cnt = 0, xfer_cnt = 0, runs = 0;
  typedef struct {
    int load_mode;
    int done_delay;
    int stall_at;
    int stall_len;
    bit rd_rand;
    bit exp_err;
    int exp_runs;
  } vec_t;
  vec_t tbl[6];
  always #5 clk = ~clk;
  // core model: result at an index is a salted hash of that index
  assign fir_y = (fir_addr * 32'h9E3779B1) ^ salt;
  fir_seq_ctrl #(.signalCount(N), .timeoutCycles(T)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fir_operation(fir_operation), .fir_addr(fir_addr), .fir_x(fir_x),
    .fir_y(fir_y), .fir_done(fir_done), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .busy(busy), .run_done(run_done), .err(err)
  );
  function automatic logic [31:0] fy(input int a);
    return (32'(a) * 32'h9E3779B1) ^ salt;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic monitor;
    if (pend) begin
      chk("load_op", 64'(fir_operation), 64'(2'b01));
      chk("load_x", 64'(fir_x), 64'(pend_data));
      chk("load_addr", 64'(fir_addr), 64'(exp_idx));
      exp_idx++;
    end else chk("no_stray_load", 64'(fir_operation == 2'b01), 64'(0));
    chk("run_done", 64'(run_done), 64'(pend_done));
    if (run_done) begin
      runs++;
      chk("run_loads", 64'(exp_idx), 64'(N));
      chk("run_reads", 64'(rd_idx), 64'(N));
    end
    chk("out_valid_vs_op", 64'(out_valid), 64'(fir_operation == 2'b11));
    if (!busy) begin
      exp_idx = 0;
      rd_idx = 0;
    end
    pend_done = 0;
    if (out_valid) begin
      chk("out_data", 64'(out_data), 64'(fy(rd_idx)));
      if (out_ready && !reset) begin
        chk("read_addr", 64'(fir_addr), 64'(rd_idx));
        pend_done = (rd_idx == N - 1);
        rd_idx++;
        xfer_cnt++;
      end
    end
    pend = in_ready && in_valid && !reset;
    pend_data = in_data;
    if (pend) acc_cnt++;
  endtask
  task automatic step;
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, "_op"}, 64'(fir_operation), 64'(0));
    chk({tag, "_addr"}, 64'(fir_addr), 64'(0));
    chk({tag, "_x"}, 64'(fir_x), 64'(0));
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_run_done"}, 64'(run_done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
  endtask
  task automatic do_start;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_in_ready", 64'(in_ready), 64'(1));
  endtask
  task automatic do_load(input int n, input int mode);
    int a0 = acc_cnt;
    int g = 0;
    while (acc_cnt - a0 < n && g < 200) begin
      in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? (g[0] == 1'b0) : 1'($urandom_range(0, 1));
      in_data = $urandom;
      step;
      g++;
    end
    in_valid = 1'b0;
    chk("load_count", 64'(acc_cnt - a0), 64'(n));
  endtask
  task automatic do_compute(input int d);
    int g = 0;
    while (fir_operation != 2'b10 && g < 20) begin
      step;
      g++;
    end
    chk("compute_entered", 64'(fir_operation), 64'(2'b10));
    if (d < 0) begin
      g = 0;
      while (busy && g < 3 * T) begin
        step;
        g++;
      end
    end else begin
      repeat (d) step;
      fir_done = 1'b1;
      step;
      fir_done = 1'b0;
    end
  endtask
  task automatic do_read(input int n, input int sa, input int sl, input bit rnd);
    int x0 = xfer_cnt;
    int g = 0;
    int st = 0;
    while (!out_valid && g < 20) begin
      step;
      g++;
    end
    chk("read_entered", 64'(out_valid), 64'(1));
    g = 0;
    while (xfer_cnt - x0 < n && g < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !(fir_addr == 32'(sa) && st < sl);
      if (!out_ready && !rnd) begin
        st++;
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_addr", 64'(fir_addr), 64'(sa));
      end
      step;
      g++;
    end
    out_ready = 1'b0;
    chk("read_count", 64'(xfer_cnt - x0), 64'(n));
  endtask
  task automatic run_vec(input vec_t v);
    int r0 = runs;
    int a0 = acc_cnt;
    salt = $urandom;
    do_start;
    do_load(N, v.load_mode);
    do_compute(v.done_delay);
    if (!v.exp_err) do_read(N, v.stall_at, v.stall_len, v.rd_rand);
    step;
    chk("vec_err", 64'(err), 64'(v.exp_err));
    chk("vec_runs", 64'(runs - r0), 64'(v.exp_runs));
    chk("vec_accepts", 64'(acc_cnt - a0), 64'(N));
    chk("vec_busy", 64'(busy), 64'(0));
  endtask
  initial begin
    int n;
    vec_t rv;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    fir_done = 1'b0; out_ready = 1'b0; salt = '0;
    tbl[0] = '{0, 5, -1, 0, 1'b0, 1'b0, 1};
    tbl[1] = '{1, 5, -1, 0, 1'b0, 1'b0, 1};
    tbl[2] = '{0, 3, 4, 3, 1'b0, 1'b0, 1};
    tbl[3] = '{2, T - 1, -1, 0, 1'b1, 1'b0, 1};
    tbl[4] = '{0, -1, -1, 0, 1'b0, 1'b1, 0};
    tbl[5] = '{2, 0, 0, 2, 1'b0, 1'b0, 1};
    @(posedge clk);
    #1;
    step;
    chk_reset("por");
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hdead;
    repeat (3) step;
    chk("idle_in_ready", 64'(in_ready), 64'(0));
    chk("idle_busy", 64'(busy), 64'(0));
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);
    for (int i = 0; i < 6; i++) begin
      rv = '{2, int'($urandom_range(0, T - 1)), -1, 0, 1'b1, 1'b0, 1};
      run_vec(rv);
    end
    salt = $urandom;
    do_start;
    do_load(N, 0);
    n = 0;
    while (fir_operation != 2'b10 && n < 20) begin
      step;
      n++;
    end
    n = 0;
    while (fir_operation == 2'b10 && n < 100) begin
      n++;
      step;
    end
    chk("timeout_cycles", 64'(n), 64'(T));
    chk("timeout_err", 64'(err), 64'(1));
    chk("timeout_busy", 64'(busy), 64'(0));
    chk("timeout_op", 64'(fir_operation), 64'(0));
    do_start;
    chk("err_cleared", 64'(err), 64'(0));
    do_load(N, 1);
    do_compute(2);
    do_read(N, -1, 0, 1'b0);
    step;
    n = runs;
    salt = $urandom;
    do_start;
    do_load(N, 2);
    while (fir_operation != 2'b10 && n < 1000) begin
      step;
      n++;
    end
    start = 1'b1;
    step;
    start = 1'b0;
    chk("ign_start_op", 64'(fir_operation), 64'(2'b10));
    chk("ign_start_busy", 64'(busy), 64'(1));
    chk("ign_start_in_ready", 64'(in_ready), 64'(0));
    fir_done = 1'b1;
    step;
    fir_done = 1'b0;
    do_read(N, -1, 0, 1'b1);
    step;
    chk("ign_start_err", 64'(err), 64'(0));
    do_start;
    do_load(6, 0);
    reset = 1'b1;
    step;
    chk_reset("rst_load");
    reset = 1'b0;
    run_vec(tbl[0]);
    salt = $urandom;
    do_start;
    do_load(N, 0);
    do_compute(4);
    do_read(3, -1, 0, 1'b0);
    chk("pre_rst_addr", 64'(fir_addr), 64'(3));
    reset = 1'b1;
    step;
    chk_reset("rst_read");
    reset = 1'b0;
    run_vec(tbl[1]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
